alu_seq: RTL
============

# alu_seq

Parametrised, clocked successor to the team's 4-bit combinational ALU. Operands are accepted through a valid/ready handshake. Most operations complete in one cycle. Multiply is an iterative shift-add taking WIDTH cycles. Results and flags are held in an output register until the consumer accepts them, so the block sits directly between a command source and a result sink in datapath tests.

## Interface
- WIDTH, 4, operand width in bits (WIDTH >= 2); result width is 2*WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/opcode present.
- in_ready  output  1  block can accept; high only in IDLE.
- A  input  WIDTH  operand A (unsigned; signed only for Overflow).
- B  input  WIDTH  operand B.
- ALU_Sel  input  3  opcode.
- out_valid  output  1  result registered and held.
- out_ready  input  1  consumer accepts result.
- ALU_Out  output  2*WIDTH  result.
- CarryOut  output  1  carry/borrow/high-half flag.
- Zero  output  1  ALU_Out == 0.
- Overflow  output  1  signed overflow (ADD/SUB only).
- Err  output  1  unsupported opcode (see Configuration).

## Operation
- Opcodes:
  - 000 ADD: ALU_Out = zero-extended (WIDTH+1)-bit sum; CarryOut = sum bit WIDTH.
  - 001 SUB: ALU_Out[WIDTH-1:0] = (A-B) mod 2^WIDTH, upper bits 0; CarryOut = borrow (A<B).
  - 010 MUL: full 2*WIDTH unsigned product; CarryOut = |product[2*WIDTH-1:WIDTH].
  - 011 OR, 100 AND, 111 XOR: low WIDTH bits, upper bits 0, CarryOut 0.
  - 101 SHL: (zero-extended A) << B, truncated to 2*WIDTH; result 0 if B >= 2*WIDTH.
  - 110 SHR: A >> B (logical), zero-extended.
- Overflow: two's-complement overflow of the WIDTH-bit ADD/SUB result; 0 for all other ops. Zero is computed on the final ALU_Out for every op.
- FSM:
  - IDLE: in_ready=1. An accept (in_valid & in_ready) latches A, B and ALU_Sel. MUL goes to BUSY; every other op goes to DONE with the result registered on that edge.
  - BUSY: one shift-add step per cycle, WIDTH steps via a counter; after the last step, goes to DONE with the product registered.
  - DONE: out_valid=1; outputs stable. If out_ready=1, goes to IDLE next edge.
- Operand inputs are ignored except at accept. in_valid is ignored while in_ready=0 and is not queued.

## Timing
- Reset (rst=1 at an edge): state IDLE; in_ready=1 after the edge; out_valid=0; ALU_Out=0; CarryOut, Zero, Overflow, Err = 0. Zero resets to 0 despite ALU_Out=0. Reset mid-BUSY or mid-DONE abandons the operation with no output.
- Non-MUL latency: accept at edge N, out_valid=1 from edge N.
- MUL latency: accept at edge N, out_valid=1 from edge N+WIDTH.
- Result consumed at the first edge with out_valid & out_ready. out_valid falls and in_ready rises after that edge.
- Back-to-back accepts are therefore no closer than 2 cycles (non-MUL) or WIDTH+2 cycles (MUL).
- Backpressure: ALU_Out and all flags are held bit-stable while out_valid=1 and out_ready=0, for any duration.
- Outputs are all registered. Flags update only on the edge entering DONE.

## Configuration
- ALU_MUL_EN defined: the iterative multiplier and BUSY state are compiled in; 010 behaves as above; Err is always 0.
- ALU_MUL_EN undefined: no multiplier logic. 010 is treated as a single-cycle op: ALU_Out=0, CarryOut=0, Overflow=0, Zero=1, Err=1. All other opcodes are unchanged.

## Test plan
- WIDTH=4: ADD A=10, B=5 -> ALU_Out=0x0F, CarryOut=0, Zero=0, Overflow=0; ADD A=15, B=3 -> 0x12, CarryOut=1.
- SUB A=5, B=15 -> ALU_Out=0x06, CarryOut=1; ADD A=7, B=1 -> 0x08, Overflow=1; XOR 1010^1100 -> 0x06; AND -> 0x08.
- MUL A=15, B=15 (ALU_MUL_EN) -> out_valid exactly 4 edges after accept, ALU_Out=0xE1, CarryOut=1; MUL 0*9 -> 0x00, Zero=1.
- Backpressure: out_ready=0 for 3 cycles after DONE -> outputs stable, in_ready=0, a concurrent in_valid is ignored; then out_ready=1 -> in_ready=1 next cycle.
- Reset mid-MUL (rst on 2nd BUSY cycle) -> out_valid=0, ALU_Out=0, in_ready=1 after the edge; a following ADD 1+1 -> 0x02.
- Without ALU_MUL_EN: MUL 3*4 -> 1-cycle latency, ALU_Out=0, Err=1, Zero=1; SHL A=1, B=7 -> 0x80; SHL B=9 -> 0x00.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Clocked, parametrised ALU with a valid/ready handshake on both
//             sides. Single-cycle ops register their result on the accept
//             edge. MUL is an iterative shift-add that takes WIDTH cycles.
//             The result and its flags stay registered and stable until the
//             consumer takes them.
//  Config   : `ALU_MUL_EN - builds in the iterative multiplier and BUSY state.
//             If it is undefined, opcode 010 finishes in one cycle with
//             ALU_Out=0, Zero=1 and Err=1.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             in_valid / in_ready  - command handshake; in_ready is high only
//                                    in IDLE
//             A, B, ALU_Sel        - operands (WIDTH bits) and opcode (3 bits)
//             out_valid / out_ready- result handshake
//             ALU_Out              - 2*WIDTH-bit result
//             CarryOut, Zero, Overflow, Err - registered flags
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [2:0]           ALU_Sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   ALU_Out,
   output logic                 CarryOut,
   output logic                 Zero,
   output logic                 Overflow,
   output logic                 Err
);

   localparam logic [2:0] C_OP_ADD = 3'b000;
   localparam logic [2:0] C_OP_SUB = 3'b001;
   localparam logic [2:0] C_OP_MUL = 3'b010;
   localparam logic [2:0] C_OP_OR  = 3'b011;
   localparam logic [2:0] C_OP_AND = 3'b100;
   localparam logic [2:0] C_OP_SHL = 3'b101;
   localparam logic [2:0] C_OP_SHR = 3'b110;
   localparam logic [2:0] C_OP_XOR = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   out_q, out_d;
   logic                 carry_q, carry_d;
   logic                 zero_q, zero_d;
   logic                 ovf_q, ovf_d;
   logic                 err_q, err_d;

   // Single-cycle result, computed straight from the input operands so it
   // can be registered on the accept edge.
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_diff;
   logic [2*WIDTH-1:0]   w_res;
   logic                 w_carry;
   logic                 w_zero;
   logic                 w_ovf;
   logic                 w_err;
   logic                 w_go_busy;

`ifdef ALU_MUL_EN
   localparam int CNT_W = $clog2(WIDTH);

   logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each step
   logic [WIDTH-1:0]     mplier_q, mplier_d; // multiplier, shifted right each step
   logic [2*WIDTH-1:0]   acc_q, acc_d;       // partial product
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   w_acc_step;

   assign w_acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign w_go_busy  = (ALU_Sel == C_OP_MUL);
`else
   assign w_go_busy  = 1'b0;
`endif

   always_comb begin
      w_sum   = {1'b0, A} + {1'b0, B};
      w_diff  = {1'b0, A} - {1'b0, B};
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      w_err   = 1'b0;
      case (ALU_Sel)
         C_OP_ADD: begin
            w_res   = {{(WIDTH-1){1'b0}}, w_sum};
            w_carry = w_sum[WIDTH];
            // Same-sign operands giving a different-sign result.
            w_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
         end
         C_OP_SUB: begin
            w_res   = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
            // The extra top bit of the widened subtraction is the borrow (A < B).
            w_carry = w_diff[WIDTH];
            w_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
         end
         C_OP_MUL: begin
`ifndef ALU_MUL_EN
            w_err = 1'b1;
`endif
         end
         C_OP_OR:  w_res = {{WIDTH{1'b0}}, A | B};
         C_OP_AND: w_res = {{WIDTH{1'b0}}, A & B};
         // A shift amount of 2*WIDTH or more clears the 2*WIDTH-bit result.
         C_OP_SHL: w_res = {{WIDTH{1'b0}}, A} << B;
         C_OP_SHR: w_res = {{WIDTH{1'b0}}, A >> B};
         C_OP_XOR: w_res = {{WIDTH{1'b0}}, A ^ B};
         default:  w_res = '0;
      endcase
      w_zero = (w_res == '0);
   end

   // Next-state logic and output-register loads.
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
`ifdef ALU_MUL_EN
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (w_go_busy) begin
                  state_d  = S_BUSY;
`ifdef ALU_MUL_EN
                  mcand_d  = {{WIDTH{1'b0}}, A};
                  mplier_d = B;
                  acc_d    = '0;
                  cnt_d    = '0;
`endif
               end else begin
                  state_d = S_DONE;
                  out_d   = w_res;
                  carry_d = w_carry;
                  zero_d  = w_zero;
                  ovf_d   = w_ovf;
                  err_d   = w_err;
               end
            end
         end
         S_BUSY: begin
`ifdef ALU_MUL_EN
            acc_d    = w_acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // The last step writes the finished product directly into the
            // output register, so DONE begins WIDTH edges after accept.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_DONE;
               out_d   = w_acc_step;
               carry_d = |w_acc_step[2*WIDTH-1:WIDTH];
               zero_d  = (w_acc_step == '0);
               ovf_d   = 1'b0;
               err_d   = 1'b0;
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         out_q    <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
`ifdef ALU_MUL_EN
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
`ifdef ALU_MUL_EN
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign ALU_Out   = out_q;
   assign CarryOut  = carry_q;
   assign Zero      = zero_q;
   assign Overflow  = ovf_q;
   assign Err       = err_q;

endmodule
`default_nettype wire
